// File: rtl/burst_gate_ctrl.sv
// -----------------------------------------------------------------------------
// burst_gate_ctrl
//
// Line-timing controller in front of color_decoder. It watches the raw 12-bit
// composite stream for horizontal sync tips, measures the line period, and
// from the recovered line position drives:
//   - the decoder's colour-burst gate (burst_active),
//   - an active-video qualifier (active_video),
//   - a line-start strobe (hsync_pulse) and the line position (line_cnt),
//   - a lock flag (locked) telling downstream logic pixel positions are valid.
//
// Ports
//   clk           in   1   74.25 MHz pixel/ADC clock
//   rst           in   1   synchronous, active-high reset
//   adc_raw       in   12  unsigned composite sample, same clock domain
//   burst_active  out  1   burst gate window to color_decoder
//   active_video  out  1   high during the active portion of locked lines
//   hsync_pulse   out  1   one-cycle strobe at each line start
//   line_cnt      out  13  clocks since last line start, saturates at 8191
//   locked        out  1   line timing locked
//   state_dbg     out  1   FSM state (0 = SEARCH, 1 = TRACK)
//
// Optional feature macro: FLYWHEEL_EN
//   When defined, a missed sync while locked synthesizes a line start instead
//   of dropping lock; lock drops only after more than MAX_MISS consecutive
//   missed syncs. When undefined, any missed sync returns to SEARCH.
//
// Handshake: there is no valid/ready flow control in this block. adc_raw is
// a free-running sample stream accepted every clock; all outputs are
// registered levels/strobes that are valid every clock.
//
// Sync detection timing: adc_raw is registered once (adc_q), and the low-run
// counter runs on adc_q. A sync is confirmed on the clock edge at which the
// run count reaches SYNC_MIN, so a tip first sampled at edge 0 produces
// hsync_pulse (and line_cnt = 0) after edge SYNC_MIN, i.e. 1 + SYNC_MIN clocks
// from the sample being presented.
// -----------------------------------------------------------------------------
module burst_gate_ctrl #(
  parameter logic [11:0] SYNC_THRESH  = 12'd1900,
  parameter int          SYNC_MIN     = 148,
  parameter int          LINE_NOM     = 4719,
  parameter int          LINE_TOL     = 64,
  parameter int          BURST_START  = 394,
  parameter int          BURST_LEN    = 186,
  parameter int          ACTIVE_START = 809,
  parameter int          ACTIVE_LEN   = 3840,
  parameter int          LOCK_LINES   = 8
`ifdef FLYWHEEL_EN
  ,
  parameter int          MAX_MISS     = 4
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] adc_raw,
  output logic        burst_active,
  output logic        active_video,
  output logic        hsync_pulse,
  output logic [12:0] line_cnt,
  output logic        locked,
  output logic        state_dbg
);

  // ---------------------------------------------------------------------------
  // Sized constants
  // ---------------------------------------------------------------------------
  localparam int RUN_W  = $clog2(SYNC_MIN + 1);
  localparam int GOOD_W = $clog2(LOCK_LINES + 1);

  localparam logic [RUN_W-1:0]  RUN_SAT   = RUN_W'(SYNC_MIN);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(SYNC_MIN - 1);

  localparam logic [12:0] LINE_LO  = 13'(LINE_NOM - LINE_TOL);
  localparam logic [12:0] LINE_HI  = 13'(LINE_NOM + LINE_TOL);
  localparam logic [12:0] BURST_LO = 13'(BURST_START);
  localparam logic [12:0] BURST_HI = 13'(BURST_START + BURST_LEN - 1);
  localparam logic [12:0] ACT_LO   = 13'(ACTIVE_START);
  localparam logic [12:0] ACT_HI   = 13'(ACTIVE_START + ACTIVE_LEN - 1);
  localparam logic [12:0] CNT_SAT  = 13'h1FFF;

  localparam logic [GOOD_W-1:0] GOOD_SAT  = GOOD_W'(LOCK_LINES);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_LINES - 1);

`ifdef FLYWHEEL_EN
  localparam int                MISS_W     = $clog2(MAX_MISS + 2);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISS);
`endif

  // ---------------------------------------------------------------------------
  // FSM state
  // ---------------------------------------------------------------------------
  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  state_t state;

  assign state_dbg = (state == TRACK);

  // ---------------------------------------------------------------------------
  // Input register and low-run counter
  // ---------------------------------------------------------------------------
  logic [11:0]      adc_q;
  logic [RUN_W-1:0] run_cnt;
  logic             sample_low;
  logic             confirm;

  // The reset value is a blanking level, so an input that is already low when
  // reset releases starts a fresh run on the first post-reset sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_q <= 12'hFFF;
    end else begin
      adc_q <= adc_raw;
    end
  end

  assign sample_low = (adc_q < SYNC_THRESH);

  // Saturating at SYNC_MIN means a long tip can only confirm once.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (!sample_low) begin
      run_cnt <= '0;
    end else if (run_cnt != RUN_SAT) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // High during the cycle whose edge takes the count to SYNC_MIN.
  assign confirm = sample_low && (run_cnt == RUN_LAST);

  // ---------------------------------------------------------------------------
  // Line-position decode
  // ---------------------------------------------------------------------------
  logic in_accept;   // line_cnt inside the accepted period window
  logic good_line;   // confirm that closes a line of acceptable length
  logic timeout;     // line would run past the accepted window
  logic burst_win;
  logic act_win;

  always_comb begin
    in_accept = (line_cnt >= LINE_LO) && (line_cnt <= LINE_HI);
    good_line = (state == TRACK) && confirm && in_accept;
    // line_cnt == LINE_HI means the next edge would reach LINE_HI + 1.
    // A confirm on that same cycle wins because good_line is checked first.
    timeout   = (state == TRACK) && (line_cnt >= LINE_HI);
    burst_win = (line_cnt >= BURST_LO) && (line_cnt <= BURST_HI);
    act_win   = (line_cnt >= ACT_LO) && (line_cnt <= ACT_HI);
  end

  // ---------------------------------------------------------------------------
  // Line FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [GOOD_W-1:0] good_cnt;
`ifdef FLYWHEEL_EN
  logic [MISS_W-1:0] miss_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEARCH;
      line_cnt     <= '0;
      hsync_pulse  <= 1'b0;
      burst_active <= 1'b0;
      active_video <= 1'b0;
      locked       <= 1'b0;
      good_cnt     <= '0;
`ifdef FLYWHEEL_EN
      miss_cnt     <= '0;
`endif
    end else begin
      hsync_pulse <= 1'b0;

      case (state)
        SEARCH: begin
          line_cnt     <= '0;
          burst_active <= 1'b0;
          active_video <= 1'b0;
          locked       <= 1'b0;
          good_cnt     <= '0;
`ifdef FLYWHEEL_EN
          miss_cnt     <= '0;
`endif
          if (confirm) begin
            state       <= TRACK;
            hsync_pulse <= 1'b1;
          end
        end

        TRACK: begin
          if (line_cnt != CNT_SAT) begin
            line_cnt <= line_cnt + 13'd1;
          end
          // Burst gate runs whether or not locked so the decoder PLL can
          // acquire; active video is only qualified on locked lines.
          burst_active <= burst_win;
          active_video <= act_win && locked;

          if (good_line) begin
            hsync_pulse  <= 1'b1;
            line_cnt     <= '0;
            // A line start closes any open window immediately.
            burst_active <= 1'b0;
            active_video <= 1'b0;
            if (good_cnt != GOOD_SAT) begin
              good_cnt <= good_cnt + 1'b1;
            end
            if (good_cnt >= GOOD_LAST) begin
              locked <= 1'b1;
            end
`ifdef FLYWHEEL_EN
            miss_cnt <= '0;
`endif
          end else if (timeout) begin
`ifdef FLYWHEEL_EN
            if (locked && (miss_cnt < MISS_LIMIT)) begin
              // Flywheel: keep the line grid running on the expected period.
              hsync_pulse  <= 1'b1;
              line_cnt     <= '0;
              burst_active <= 1'b0;
              active_video <= 1'b0;
              miss_cnt     <= miss_cnt + 1'b1;
            end else begin
              state        <= SEARCH;
              line_cnt     <= '0;
              burst_active <= 1'b0;
              active_video <= 1'b0;
              locked       <= 1'b0;
              good_cnt     <= '0;
              miss_cnt     <= '0;
            end
`else
            state        <= SEARCH;
            line_cnt     <= '0;
            burst_active <= 1'b0;
            active_video <= 1'b0;
            locked       <= 1'b0;
            good_cnt     <= '0;
`endif
          end
        end

        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule
